coeff_bank: RTL and testbench

COEFF_BANK -- requirements
Module: coeff_bank

---
 rtl/coeff_pkg.sv | 35 +++
 rtl/biquad_stab_check.sv | 25 ++
 rtl/coeff_bank.sv | 175 +++++++++++++++++
 tb/tb_coeff_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_pkg.sv
// Shared definitions for the coefficient bank: Q2.14 constants, frame field
// offsets, the unity coefficient set and the bank's FSM state type.
package coeff_pkg;

    localparam int COEFF_W   = 16;
    localparam int BAND_W    = 80;
    localparam int NUM_BANDS = 3;
    localparam int SET_W     = BAND_W * NUM_BANDS;

    localparam logic [COEFF_W-1:0] Q14_ONE = 16'h4000;

    // Band base offsets within a 240-bit set; the low band occupies the top bits.
    localparam int LOW_LSB  = 160;
    localparam int MID_LSB  = 80;
    localparam int HIGH_LSB = 0;

    // Coefficient offsets within one 80-bit band, b0 at the top.
    localparam int B0_OFS = 64;
    localparam int B1_OFS = 48;
    localparam int B2_OFS = 32;
    localparam int A1_OFS = 16;
    localparam int A2_OFS = 0;

    localparam logic [BAND_W-1:0] UNITY_BAND = {Q14_ONE, 64'h0};
    localparam logic [SET_W-1:0]  UNITY_SET  = {NUM_BANDS{UNITY_BAND}};

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CHECK,
        PENDING,
        COMMIT
    } coeff_bank_state_t;

endpackage

// File: rtl/biquad_stab_check.sv
// Combinational stability test for one biquad band: passes when the pole
// pair (a1, a2) lies strictly inside the stability triangle.
module biquad_stab_check
    import coeff_pkg::*;
(
    input  logic signed [COEFF_W-1:0] a1,
    input  logic signed [COEFF_W-1:0] a2,
    output logic                      pass
);

    logic signed [COEFF_W:0] a1_x;
    logic signed [COEFF_W:0] a2_x;
    logic signed [COEFF_W:0] a1_abs;
    logic signed [COEFF_W:0] limit;

    // One extra bit so that |-32768| is representable.
    always_comb begin
        a1_x   = {a1[COEFF_W-1], a1};
        a2_x   = {a2[COEFF_W-1], a2};
        a1_abs = a1_x[COEFF_W] ? -a1_x : a1_x;
        limit  = 17'sd16384 + a2_x;
        pass   = (a2_x > -17'sd16384) && (a2_x < 17'sd16384) && (a1_abs < limit);
    end

endmodule

// File: rtl/coeff_bank.sv
// Double-buffered biquad coefficient bank: captures SPI frames into a shadow
// set and commits on an audio sample boundary. Optional stability screening
// is enabled by defining COEFF_BANK_STABILITY_CHECK_EN.
module coeff_bank
    import coeff_pkg::*;
#(
    parameter int REJ_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SET_W-1:0]     coeff_in,
    input  logic                 in_valid,
    input  logic                 sample_tick,
    output logic [SET_W-1:0]     coeff_out,
    output logic                 update_pulse,
    output logic                 pending,
    output logic                 reject_pulse,
    output logic [REJ_CNT_W-1:0] reject_count
);

    coeff_bank_state_t state;
    coeff_bank_state_t next_state;

    logic             in_valid_q;
    logic             in_valid_qq;
    logic             frame_edge;
    logic [SET_W-1:0] shadow;
    logic             deferred;
    logic             deferred_next;
    logic             load_shadow;
    logic             commit_set;

`ifdef COEFF_BANK_STABILITY_CHECK_EN
    logic [1:0]         band_cnt;
    logic [COEFF_W-1:0] a1_sel;
    logic [COEFF_W-1:0] a2_sel;
    logic               band_pass;
    logic               check_fail;

    always_comb begin
        case (band_cnt)
            2'd0: begin
                a1_sel = shadow[LOW_LSB + A1_OFS +: COEFF_W];
                a2_sel = shadow[LOW_LSB + A2_OFS +: COEFF_W];
            end
            2'd1: begin
                a1_sel = shadow[MID_LSB + A1_OFS +: COEFF_W];
                a2_sel = shadow[MID_LSB + A2_OFS +: COEFF_W];
            end
            default: begin
                a1_sel = shadow[HIGH_LSB + A1_OFS +: COEFF_W];
                a2_sel = shadow[HIGH_LSB + A2_OFS +: COEFF_W];
            end
        endcase
    end

    biquad_stab_check u_stab (
        .a1   (a1_sel),
        .a2   (a2_sel),
        .pass (band_pass)
    );
`endif

    // A frame is the registered rising edge of the level-type valid.
    assign frame_edge = in_valid_q & ~in_valid_qq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        deferred_next = deferred;
        load_shadow   = 1'b0;
        commit_set    = 1'b0;
`ifdef COEFF_BANK_STABILITY_CHECK_EN
        check_fail    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (frame_edge) next_state = CAPTURE;
            end
            CAPTURE: begin
                load_shadow = 1'b1;
                if (frame_edge) begin
                    next_state = CAPTURE;
                end else begin
`ifdef COEFF_BANK_STABILITY_CHECK_EN
                    next_state = CHECK;
`else
                    next_state = PENDING;
`endif
                end
            end
`ifdef COEFF_BANK_STABILITY_CHECK_EN
            CHECK: begin
                if (frame_edge) begin
                    next_state = CAPTURE;
                end else if (!band_pass) begin
                    check_fail = 1'b1;
                    next_state = IDLE;
                end else if (band_cnt == 2'd2) begin
                    next_state = PENDING;
                end
            end
`endif
            PENDING: begin
                // A frame arriving with the tick waits until the commit is done.
                if (sample_tick) begin
                    commit_set = 1'b1;
                    next_state = COMMIT;
                    if (frame_edge) deferred_next = 1'b1;
                end else if (frame_edge) begin
                    next_state = CAPTURE;
                end
            end
            COMMIT: begin
                deferred_next = 1'b0;
                next_state    = (deferred || frame_edge) ? CAPTURE : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_valid_q  <= 1'b0;
            in_valid_qq <= 1'b0;
            deferred    <= 1'b0;
            shadow      <= UNITY_SET;
            coeff_out   <= UNITY_SET;
        end else begin
            in_valid_q  <= in_valid;
            in_valid_qq <= in_valid_q;
            deferred    <= deferred_next;
            if (load_shadow) begin
                shadow <= coeff_in;
`ifdef COEFF_BANK_STABILITY_CHECK_EN
            end else if (check_fail) begin
                shadow <= UNITY_SET;
`endif
            end
            if (commit_set) coeff_out <= shadow;
        end
    end

`ifdef COEFF_BANK_STABILITY_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            band_cnt     <= 2'd0;
            reject_pulse <= 1'b0;
            reject_count <= '0;
        end else begin
            band_cnt     <= (state == CHECK) ? band_cnt + 2'd1 : 2'd0;
            reject_pulse <= check_fail;
            if (check_fail && (reject_count != {REJ_CNT_W{1'b1}})) begin
                reject_count <= reject_count + REJ_CNT_W'(1);
            end
        end
    end
`else
    assign reject_pulse = 1'b0;
    assign reject_count = '0;
`endif

    assign pending      = (state == PENDING);
    assign update_pulse = (state == COMMIT);

endmodule

// File: tb/tb_coeff_bank.sv
// Directed self-checking bench for coeff_bank; expectations follow the
// COEFF_BANK_STABILITY_CHECK_EN setting of the build.
`timescale 1ns/1ps
module tb_coeff_bank;

`ifdef COEFF_BANK_STABILITY_CHECK_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    localparam logic [79:0]  UB    = {16'h4000, 64'h0};
    localparam logic [239:0] UNITY = {UB, UB, UB};
    localparam logic [239:0] F_A   = {16'h1234, 16'h5678, 16'h9ABC, 16'h0800, 16'h1111,
                                      16'h2000, 16'h0100, 16'h0200, 16'hF800, 16'h0400,
                                      16'h3000, 16'h0300, 16'h0400, 16'h0C00, 16'hFC00};
    localparam logic [239:0] F_REJ = {16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h4000, UB, UB};
    localparam logic [239:0] F_FAIL_MID  = {UB, 16'h4000, 16'h0000, 16'h0000, 16'h8000, 16'h3FFF, UB};
    localparam logic [239:0] F_PASS_EDGE = {16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'hC001, UB,
                                            16'h4000, 16'h0000, 16'h0000, 16'h7FFE, 16'h3FFF};
    localparam logic [239:0] F_B1  = {16'h0001, 16'h0002, 16'h0003, 16'h0100, 16'h0200,
                                      16'h0004, 16'h0005, 16'h0006, 16'h0300, 16'h0400,
                                      16'h0007, 16'h0008, 16'h0009, 16'h0500, 16'h0600};
    localparam logic [239:0] F_B2  = {16'hF001, 16'hF002, 16'hF003, 16'hFF00, 16'h0200,
                                      16'hF004, 16'hF005, 16'hF006, 16'hFD00, 16'h0400,
                                      16'hF007, 16'hF008, 16'hF009, 16'hFB00, 16'h0600};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [239:0] coeff_in = '0;
    logic         in_valid = 1'b0;
    logic         sample_tick = 1'b0;
    logic [239:0] coeff_out;
    logic         update_pulse;
    logic         pending;
    logic         reject_pulse;
    logic [7:0]   reject_count;

    int vectors = 0;
    int miscompares = 0;

    coeff_bank #(.REJ_CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .coeff_in     (coeff_in),
        .in_valid     (in_valid),
        .sample_tick  (sample_tick),
        .coeff_out    (coeff_out),
        .update_pulse (update_pulse),
        .pending      (pending),
        .reject_pulse (reject_pulse),
        .reject_count (reject_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [239:0] f);
        coeff_in = f;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        vectors++; if (coeff_out !== UNITY) begin miscompares++; $display("[TB] FAIL reset_coeff: got %h expected %h", coeff_out, UNITY); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pending: got %b expected 0", pending); end
        vectors++; if (update_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_update: got %b expected 0", update_pulse); end
        vectors++; if (reject_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_reject: got %b expected 0", reject_pulse); end
        vectors++; if (reject_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_rej_cnt: got %0d expected 0", reject_count); end
    endtask

    task automatic test_tick_ignored();
        pulse_tick();
        vectors++; if (update_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_tick_update: got %b expected 0", update_pulse); end
        vectors++; if (coeff_out !== UNITY) begin miscompares++; $display("[TB] FAIL idle_tick_coeff: got %h expected %h", coeff_out, UNITY); end
        step(1);
    endtask

    task automatic test_commit();
        send_frame(F_A);
        step(LAT - 1);
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL commit_pend_early: got %b expected 0", pending); end
        step(1);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL commit_pend: got %b expected 1", pending); end
        step(3);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL commit_pend_hold: got %b expected 1", pending); end
        vectors++; if (coeff_out !== UNITY) begin miscompares++; $display("[TB] FAIL commit_no_early_out: got %h expected %h", coeff_out, UNITY); end
        pulse_tick();
        vectors++; if (coeff_out !== F_A) begin miscompares++; $display("[TB] FAIL commit_out: got %h expected %h", coeff_out, F_A); end
        vectors++; if (update_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL commit_update: got %b expected 1", update_pulse); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL commit_pend_clr: got %b expected 0", pending); end
        step(1);
        vectors++; if (update_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL commit_update_1cyc: got %b expected 0", update_pulse); end
    endtask

    task automatic test_reject();
        send_frame(F_REJ);
`ifdef COEFF_BANK_STABILITY_CHECK_EN
        step(2);
        vectors++; if (reject_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL rej_early: got %b expected 0", reject_pulse); end
        step(1);
        vectors++; if (reject_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL rej_pulse: got %b expected 1", reject_pulse); end
        vectors++; if (reject_count !== 8'd1) begin miscompares++; $display("[TB] FAIL rej_count: got %0d expected 1", reject_count); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL rej_pending: got %b expected 0", pending); end
        step(1);
        vectors++; if (reject_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL rej_pulse_1cyc: got %b expected 0", reject_pulse); end
        vectors++; if (coeff_out !== F_A) begin miscompares++; $display("[TB] FAIL rej_coeff_kept: got %h expected %h", coeff_out, F_A); end
        // |-32768| must not wrap: the mid band fails on the second check cycle.
        send_frame(F_FAIL_MID);
        step(3);
        vectors++; if (reject_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL rej_mid_early: got %b expected 0", reject_pulse); end
        step(1);
        vectors++; if (reject_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL rej_mid_pulse: got %b expected 1", reject_pulse); end
        vectors++; if (reject_count !== 8'd2) begin miscompares++; $display("[TB] FAIL rej_mid_count: got %0d expected 2", reject_count); end
        step(1);
`else
        step(LAT);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL nochk_pend: got %b expected 1", pending); end
        vectors++; if (reject_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL nochk_reject: got %b expected 0", reject_pulse); end
        vectors++; if (reject_count !== 8'd0) begin miscompares++; $display("[TB] FAIL nochk_rej_cnt: got %0d expected 0", reject_count); end
        pulse_tick();
        vectors++; if (coeff_out !== F_REJ) begin miscompares++; $display("[TB] FAIL nochk_commit: got %h expected %h", coeff_out, F_REJ); end
        step(1);
`endif
        send_frame(F_PASS_EDGE);
        step(LAT);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_pass_pend: got %b expected 1", pending); end
        pulse_tick();
        vectors++; if (coeff_out !== F_PASS_EDGE) begin miscompares++; $display("[TB] FAIL edge_pass_out: got %h expected %h", coeff_out, F_PASS_EDGE); end
        step(1);
    endtask

    task automatic test_last_wins();
        send_frame(F_B1);
        step(1);
        send_frame(F_B2);
        step(LAT - 1);
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL last_pend_early: got %b expected 0", pending); end
        step(1);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL last_pend: got %b expected 1", pending); end
        vectors++; if (coeff_out !== F_PASS_EDGE) begin miscompares++; $display("[TB] FAIL last_no_early_out: got %h expected %h", coeff_out, F_PASS_EDGE); end
        pulse_tick();
        vectors++; if (coeff_out !== F_B2) begin miscompares++; $display("[TB] FAIL last_out: got %h expected %h", coeff_out, F_B2); end
        step(1);
    endtask

    task automatic test_back_to_back();
        send_frame(F_A);
        step(LAT);
        coeff_in = F_B1;
        in_valid = 1'b1;
        step(1);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_pend_before: got %b expected 1", pending); end
        in_valid = 1'b0;
        pulse_tick();
        vectors++; if (update_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_update: got %b expected 1", update_pulse); end
        vectors++; if (coeff_out !== F_A) begin miscompares++; $display("[TB] FAIL b2b_first_out: got %h expected %h", coeff_out, F_A); end
        step(LAT - 1);
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_pend_early: got %b expected 0", pending); end
        step(1);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_pend_second: got %b expected 1", pending); end
        pulse_tick();
        vectors++; if (coeff_out !== F_B1) begin miscompares++; $display("[TB] FAIL b2b_second_out: got %h expected %h", coeff_out, F_B1); end
        step(1);
    endtask

    task automatic test_edge_in_commit();
        send_frame(F_A);
        step(LAT);
        coeff_in    = F_B2;
        in_valid    = 1'b1;
        sample_tick = 1'b1;
        step(1);
        in_valid    = 1'b0;
        sample_tick = 1'b0;
        vectors++; if (coeff_out !== F_A) begin miscompares++; $display("[TB] FAIL cedge_first_out: got %h expected %h", coeff_out, F_A); end
        step(LAT - 1);
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL cedge_pend_early: got %b expected 0", pending); end
        step(1);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL cedge_pend: got %b expected 1", pending); end
        pulse_tick();
        vectors++; if (coeff_out !== F_B2) begin miscompares++; $display("[TB] FAIL cedge_second_out: got %h expected %h", coeff_out, F_B2); end
        step(1);
    endtask

    task automatic test_saturation();
`ifdef COEFF_BANK_STABILITY_CHECK_EN
        for (int i = 0; i < 256; i++) begin
            send_frame(F_REJ);
            step(4);
        end
        vectors++; if (reject_count !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_count: got %0d expected 255", reject_count); end
        send_frame(F_REJ);
        step(3);
        vectors++; if (reject_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_pulse: got %b expected 1", reject_pulse); end
        vectors++; if (reject_count !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_hold: got %0d expected 255", reject_count); end
        step(1);
`else
        vectors++; if (reject_count !== 8'd0) begin miscompares++; $display("[TB] FAIL nochk_sat_count: got %0d expected 0", reject_count); end
`endif
        vectors++; if (coeff_out !== F_B2) begin miscompares++; $display("[TB] FAIL sat_coeff_kept: got %h expected %h", coeff_out, F_B2); end
    endtask

    task automatic test_reset_pending();
        send_frame(F_B1);
        step(LAT);
        vectors++; if (pending !== 1'b1) begin miscompares++; $display("[TB] FAIL rstp_pend_before: got %b expected 1", pending); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (coeff_out !== UNITY) begin miscompares++; $display("[TB] FAIL rstp_async_coeff: got %h expected %h", coeff_out, UNITY); end
        vectors++; if (pending !== 1'b0) begin miscompares++; $display("[TB] FAIL rstp_async_pend: got %b expected 0", pending); end
        vectors++; if (reject_count !== 8'd0) begin miscompares++; $display("[TB] FAIL rstp_rej_cnt: got %0d expected 0", reject_count); end
        step(1);
        reset = 1'b1;
        step(1);
        pulse_tick();
        vectors++; if (update_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL rstp_tick_update: got %b expected 0", update_pulse); end
        vectors++; if (coeff_out !== UNITY) begin miscompares++; $display("[TB] FAIL rstp_tick_coeff: got %h expected %h", coeff_out, UNITY); end
        step(1);
    endtask

    initial begin
        test_reset();
        test_tick_ignored();
        test_commit();
        test_reject();
        test_last_wins();
        test_back_to_back();
        test_edge_in_commit();
        test_saturation();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
